// File: rtl/pe_module.sv
// pe_module: processing element for a systolic-array matrix multiplier.
//
// Each cycle it registers the A operand toward the right-hand neighbour and
// the B operand toward the lower neighbour. It also accumulates a*b into a
// local result register. All outputs come straight from flops.
//
// Parameters:
//   DATA_W  width of the operands, the forwarded operands and the result (default 8)
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous, active-high reset; clears every register
//   a      in   [DATA_W-1:0] unsigned A operand (left neighbour / array edge)
//   b      in   [DATA_W-1:0] unsigned B operand (upper neighbour / array edge)
//   a_out  out  [DATA_W-1:0] registered copy of a
//   b_out  out  [DATA_W-1:0] registered copy of b
//   out    out  [DATA_W-1:0] accumulated result
//
// Build option:
//   PE_SATURATE_EN  when defined, the accumulator clamps at 2^DATA_W-1
//                   instead of wrapping modulo 2^DATA_W.
module pe_module #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [DATA_W-1:0] out
);

  logic [DATA_W-1:0]   a_out_q, a_out_d;
  logic [DATA_W-1:0]   b_out_q, b_out_d;
  logic [DATA_W-1:0]   out_q,   out_d;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W:0]   sum;

  always_comb begin
    a_out_d = a;
    b_out_d = b;
    prod    = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    sum     = {{(DATA_W+1){1'b0}}, out_q} + {1'b0, prod};
  end

`ifdef PE_SATURATE_EN
  // Any bit above the result width means the true sum exceeds the maximum.
  // Operands are unsigned, so a clamped value can only stay at the maximum.
  always_comb begin
    out_d = sum[DATA_W-1:0];
    if (|sum[2*DATA_W:DATA_W]) begin
      out_d = '1;
    end
  end
`else
  logic unused_sum_hi;

  always_comb begin
    out_d         = sum[DATA_W-1:0];
    unused_sum_hi = ^sum[2*DATA_W:DATA_W];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_out_q <= '0;
      b_out_q <= '0;
      out_q   <= '0;
    end else begin
      a_out_q <= a_out_d;
      b_out_q <= b_out_d;
      out_q   <= out_d;
    end
  end

  assign a_out = a_out_q;
  assign b_out = b_out_q;
  assign out   = out_q;

endmodule

// File: tb/tb_pe_module.sv
module tb_pe_module;

  localparam int W = 8;

`ifdef PE_SATURATE_EN
  localparam int EXP_WRAP = 255;
  localparam int EXP_MAX  = 255;
`else
  localparam int EXP_WRAP = 30;
  localparam int EXP_MAX  = 1;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] a_out;
  logic [W-1:0] b_out;
  logic [W-1:0] out;

  int errors = 0;
  int checks = 0;

  // Reference state: the values the outputs should show after the last edge.
  int unsigned m_a;
  int unsigned m_b;
  int unsigned m_out;

  pe_module #(.DATA_W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .a_out (a_out),
    .b_out (b_out),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, wait for the edge, and advance the reference.
  task automatic drive_cycle(input logic r, input int unsigned av, input int unsigned bv);
    int unsigned total;
    rst = r;
    a   = av[W-1:0];
    b   = bv[W-1:0];
    @(posedge clk);
    #1;
    if (r) begin
      m_a   = 0;
      m_b   = 0;
      m_out = 0;
    end else begin
      m_a   = av % 256;
      m_b   = bv % 256;
      total = m_out + m_a * m_b;
`ifdef PE_SATURATE_EN
      m_out = (total > 255) ? 255 : total;
`else
      m_out = total % 256;
`endif
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 13, 11);
      checks++;
      if (a_out !== 8'd0) begin
        errors++;
        $display("FAIL reset_a_out cycle %0d: got %0d expected 0", i, a_out);
      end
      checks++;
      if (b_out !== 8'd0) begin
        errors++;
        $display("FAIL reset_b_out cycle %0d: got %0d expected 0", i, b_out);
      end
      checks++;
      if (out !== 8'd0) begin
        errors++;
        $display("FAIL reset_out cycle %0d: got %0d expected 0", i, out);
      end
    end
  endtask

  task automatic test_forward_accum;
    drive_cycle(1'b0, 13, 11);
    checks++;
    if (a_out !== 8'd13) begin
      errors++;
      $display("FAIL fwd_a_out: got %0d expected 13", a_out);
    end
    checks++;
    if (b_out !== 8'd11) begin
      errors++;
      $display("FAIL fwd_b_out: got %0d expected 11", b_out);
    end
    checks++;
    if (out !== 8'd143) begin
      errors++;
      $display("FAIL fwd_out: got %0d expected 143", out);
    end
  endtask

  task automatic test_wrap;
    drive_cycle(1'b0, 13, 11);
    checks++;
    if (out !== EXP_WRAP[W-1:0]) begin
      errors++;
      $display("FAIL wrap_out: got %0d expected %0d", out, EXP_WRAP);
    end
  endtask

  task automatic test_operand_change;
    drive_cycle(1'b1, 0, 0);
    drive_cycle(1'b0, 13, 11);
    drive_cycle(1'b0, 1, 3);
    checks++;
    if (out !== 8'd146) begin
      errors++;
      $display("FAIL opchg_out: got %0d expected 146", out);
    end
    checks++;
    if (a_out !== 8'd1) begin
      errors++;
      $display("FAIL opchg_a_out: got %0d expected 1", a_out);
    end
    checks++;
    if (b_out !== 8'd3) begin
      errors++;
      $display("FAIL opchg_b_out: got %0d expected 3", b_out);
    end
  endtask

  task automatic test_max_operands;
    drive_cycle(1'b1, 0, 0);
    drive_cycle(1'b0, 255, 255);
    checks++;
    if (out !== EXP_MAX[W-1:0]) begin
      errors++;
      $display("FAIL max_out: got %0d expected %0d", out, EXP_MAX);
    end
  endtask

  task automatic test_zero_hold;
    drive_cycle(1'b1, 0, 0);
    drive_cycle(1'b0, 7, 9);
    drive_cycle(1'b0, 0, 200);
    drive_cycle(1'b0, 150, 0);
    checks++;
    if (out !== 8'd63) begin
      errors++;
      $display("FAIL zero_hold_out: got %0d expected 63", out);
    end
    checks++;
    if (a_out !== 8'd150 || b_out !== 8'd0) begin
      errors++;
      $display("FAIL zero_hold_fwd: got a_out=%0d b_out=%0d expected 150/0", a_out, b_out);
    end
  endtask

  task automatic test_reset_mid;
    drive_cycle(1'b1, 0, 0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 2, 5);
    checks++;
    if (out !== 8'd30) begin
      errors++;
      $display("FAIL mid_pre_out: got %0d expected 30", out);
    end
    drive_cycle(1'b1, 2, 5);
    checks++;
    if (out !== 8'd0 || a_out !== 8'd0 || b_out !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: got out=%0d a_out=%0d b_out=%0d expected 0/0/0", out, a_out, b_out);
    end
    drive_cycle(1'b0, 2, 5);
    checks++;
    if (out !== 8'd10) begin
      errors++;
      $display("FAIL mid_release_out: got %0d expected 10", out);
    end
  endtask

  task automatic test_random;
    drive_cycle(1'b1, 0, 0);
    for (int i = 0; i < 300; i++) begin
      logic        r;
      int unsigned av;
      int unsigned bv;
      r  = ($urandom_range(0, 24) == 0);
      // Small operands most of the time so wrap/saturation is reached gradually.
      av = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
      bv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
      drive_cycle(r, av, bv);
      checks++;
      if (a_out !== m_a[W-1:0] || b_out !== m_b[W-1:0] || out !== m_out[W-1:0]) begin
        errors++;
        $display("FAIL random cycle %0d: got a_out=%0d b_out=%0d out=%0d expected %0d/%0d/%0d",
                 i, a_out, b_out, out, m_a, m_b, m_out);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    a     = '0;
    b     = '0;
    m_a   = 0;
    m_b   = 0;
    m_out = 0;
    test_reset();
    test_forward_accum();
    test_wrap();
    test_operand_change();
    test_max_operands();
    test_zero_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_module.md
Name: pe_module

Overview:
- Processing element (PE) for a systolic-array matrix multiplier.
- Each cycle it forwards its A operand to the right-hand neighbour and its B operand to the lower neighbour, both registered.
- It multiply-accumulates a*b into a local result register, so a PE grid can be built by chaining a_out→a and b_out→b.

Parameters:
- DATA_W, 8, width of operands, forwarded operands and accumulated result.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- a  input  DATA_W  A operand, from left neighbour or array edge; unsigned.
- b  input  DATA_W  B operand, from upper neighbour or array edge; unsigned.
- a_out  output  DATA_W  registered copy of a, to right neighbour.
- b_out  output  DATA_W  registered copy of b, to lower neighbour.
- out  output  DATA_W  accumulated result register.

Behaviour:
- All outputs come directly from flops; no combinational input→output paths.
- Reset: on a rising clk edge with rst=1, a_out, b_out and out all become 0. Reset overrides any accumulate in the same cycle. Reset mid-accumulation discards the partial sum.
- Normal cycle (rst=0), on each rising edge:
  - a_out <= a
  - b_out <= b
  - out <= out + a*b
- Latency: forwarding is exactly 1 cycle. A product sampled at edge N is visible on out after edge N.
- No enable and no handshake: the PE accumulates every cycle. Operands of 0 on either input hold out unchanged. Idle/bubble slots are expressed by driving 0.
- Arithmetic:
  - Unsigned.
  - Product computed at full 2*DATA_W width.
  - Sum of out + product computed at 2*DATA_W+1 width.
  - Result truncated to the low DATA_W bits (modulo 2^DATA_W wrap) unless the optional feature is enabled.
- Inputs held constant for k cycles give out = k*a*b mod 2^DATA_W (from 0 after reset).
- X/undriven inputs are not qualified. The bench must drive defined values after reset.
- Power-up value of all registers is undefined until the first reset edge.

Optional Feature:
- Macro: PE_SATURATE_EN.
- When defined: accumulation saturates. If out + a*b exceeds 2^DATA_W-1, out <= 2^DATA_W-1 (255 for DATA_W=8). Once saturated, out stays at max until reset.
- When undefined: modulo wrap as described in Behaviour.
- Forwarding paths and reset behaviour are identical in both builds.

Test Plan:
- Reset: rst=1 for 2 cycles with a=13, b=11 → a_out=0, b_out=0, out=0 after each edge.
- Forward/accumulate: rst=0, a=13, b=11 for one cycle → a_out=13, b_out=11, out=143.
- Wrap: a=13, b=11 held a second cycle → out=30 (286 mod 256); with PE_SATURATE_EN, out=255.
- Operand change: from out=143, switch to a=1, b=3 for one cycle → out=146, a_out=1, b_out=3.
- Max operands: after reset, a=255, b=255 one cycle → out=1 (65025 mod 256); with PE_SATURATE_EN, out=255.
- Reset mid-operation: accumulate 3 cycles of a=2, b=5 (out=30), assert rst for one cycle while a=2, b=5 → out=0, a_out=0, b_out=0; release → out=10 on next edge.
